// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
// Fetched entries pair the PC with its instruction word.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;
    localparam int MIN_BUF_DEPTH = 2;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ins;
    } fetch_entry_t;

    function automatic bit buf_depth_ok(int d);
        return (d >= MIN_BUF_DEPTH) && ((d & (d - 1)) == 0);
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-to-decode valid/ready handshake.
// master = fetch side, slave = decode side.
interface fetch_if;
    import fetch_pkg::*;

    logic            dec_valid;
    logic            dec_ready;
    logic [XLEN-1:0] dec_ins;
    logic [XLEN-1:0] dec_pc;

    modport master (
        output dec_valid,
        output dec_ins,
        output dec_pc,
        input  dec_ready
    );

    modport slave (
        input  dec_valid,
        input  dec_ins,
        input  dec_pc,
        output dec_ready
    );

endinterface

// File: rtl/fetch_buf.sv
// Flushable synchronous FIFO of fetch entries.
// Head is read straight from storage; storage resets to zero.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  fetch_entry_t           wdata_i,
    output fetch_entry_t           rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  wptr_q, wptr_d;
    logic [AW-1:0]  rptr_q, rptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           do_push;
    logic           do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rptr_q];

    // A full buffer only takes a push when the head leaves the same cycle.
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + AW'(1);
            if (do_pop)  rptr_d = rptr_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_push && !flush_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage front: PC, imem addressing, fetch buffer, redirects.
// Optional FETCH_MISALIGN_CHK_EN traps misaligned redirect targets.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
`ifdef FETCH_MISALIGN_CHK_EN
    output logic        fetch_exc,
`endif
    fetch_if.master     dec
);

    localparam int  CW       = $clog2(BUF_DEPTH) + 1;
    localparam bit  DEPTH_OK = buf_depth_ok(BUF_DEPTH);
    localparam logic [1:0] RESET_LOW = RESET_PC[1:0];

    if (!DEPTH_OK) begin : g_bad_depth
        $error("fetch_unit: BUF_DEPTH must be a power of two >= 2");
    end
    if (RESET_LOW != 2'b00) begin : g_bad_reset_pc
        $error("fetch_unit: RESET_PC must be word aligned");
    end

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] target;
    logic            halted;
    logic            pop;
    logic            push;
    logic            can_fetch;
    logic            buf_full;
    logic            buf_empty;
    logic [CW-1:0]   buf_count;
    fetch_entry_t    head;
    fetch_entry_t    wentry;

`ifdef FETCH_MISALIGN_CHK_EN
    logic halted_q, halted_d;
    logic exc_q, exc_d;
    logic misalign;

    assign misalign  = (redirect_pc[1:0] != 2'b00);
    assign target    = redirect_pc;
    assign halted    = halted_q;
    assign fetch_exc = exc_q;

    // Only a redirect can enter or leave the trapped state.
    always_comb begin
        halted_d = halted_q;
        exc_d    = exc_q;
        if (redirect_valid) begin
            halted_d = misalign;
            exc_d    = misalign;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            halted_q <= 1'b0;
            exc_q    <= 1'b0;
        end else begin
            halted_q <= halted_d;
            exc_q    <= exc_d;
        end
    end
`else
    assign target = {redirect_pc[XLEN-1:2], 2'b00};
    assign halted = 1'b0;
`endif

    assign imem_addr = pc_q;

    // Redirect squashes both enqueue and dequeue for its cycle.
    assign pop       = dec.dec_valid & dec.dec_ready & ~redirect_valid;
    assign can_fetch = fetch_en & ~halted & (~buf_full | pop);
    assign push      = can_fetch & ~redirect_valid;

    assign wentry.pc  = pc_q;
    assign wentry.ins = imem_rdata;

    assign dec.dec_valid = ~buf_empty & ~halted;
    assign dec.dec_ins   = head.ins;
    assign dec.dec_pc    = head.pc;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = target;
        end else if (push) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect_valid),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wentry),
        .rdata_o (head),
        .count_o (buf_count),
        .full_o  (buf_full),
        .empty_o (buf_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (buf_count <= CW'(BUF_DEPTH))
                else $error("fetch_unit: buffer count overflow");
        end
    end

endmodule
